// File: rtl/scanner_pkg.sv
// Shared geometry, FSM state type and row helpers for the dot-matrix scanner.
package scanner_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef enum logic [1:0] {
      LATCH = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } scan_state_e;

   // Row r is driven on row_sel bit 7-r.
   function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] r);
      return 8'h80 >> r;
   endfunction

   // Row 0 sits in the top byte of the frame image.
   function automatic logic [COLS-1:0] shadow_row(input logic [ROWS*COLS-1:0] img,
                                                  input logic [2:0] r);
      logic [5:0] base;
      base = {3'd7 - r, 3'd0};
      return img[base +: COLS];
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter and row counter with slot/frame wrap strobes.
module scan_prescaler #(
   parameter int CLK_DIV = 1024,
   parameter int CNT_W   = $clog2(CLK_DIV)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] cnt,
   output logic [2:0]       row,
   output logic             slot_wrap,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       row_q, row_d;
   logic             slot_wrap_s;

   assign slot_wrap_s = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      row_d = row_q;
      if (slot_wrap_s) begin
         cnt_d = CNT_ZERO;
         row_d = row_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
         row_d = row_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= CNT_ZERO;
         row_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
         row_q <= row_d;
      end
   end

   assign cnt        = cnt_q;
   assign row        = row_q;
   assign slot_wrap  = slot_wrap_s;
   assign frame_wrap = slot_wrap_s && (row_q == 3'd7);

endmodule

// File: rtl/dot_matrix_scanner.sv
// 8x8 LED matrix row scanner with a tear-free frame shadow and registered drives.
// Optional PWM dimming from brightness[3:0] is compiled in when SCANNER_PWM_EN is defined.
module dot_matrix_scanner
   import scanner_pkg::*;
#(
   parameter int CLK_DIV   = 1024,
   parameter int BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] main_graphic,
   input  logic [31:0] brightness,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

   logic [CNT_W-1:0] cnt_s;
   logic [2:0]       row_s;
   logic             slot_wrap_s;
   logic             frame_wrap_s;
   logic             pwm_pass_s;

   scan_state_e      state_q, state_d;
   logic [63:0]      shadow_q, shadow_d;
   logic [7:0]       row_sel_q, row_sel_d;
   logic [7:0]       col_data_q, col_data_d;
   logic             frame_done_q, frame_done_d;

   scan_prescaler #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_prescaler (
      .clk        (clk),
      .reset      (reset),
      .cnt        (cnt_s),
      .row        (row_s),
      .slot_wrap  (slot_wrap_s),
      .frame_wrap (frame_wrap_s)
   );

`ifdef SCANNER_PWM_EN
   logic unused_brightness_s;
   assign unused_brightness_s = ^brightness[31:4];
   assign pwm_pass_s = (cnt_s[3:0] <= brightness[3:0]);
`else
   logic unused_brightness_s;
   assign unused_brightness_s = ^brightness;
   assign pwm_pass_s = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      row_sel_d    = 8'h00;
      col_data_d   = 8'h00;
      frame_done_d = frame_wrap_s;

      if ((row_s == 3'd0) && (cnt_s == CNT_ZERO)) begin
         shadow_d = main_graphic;
      end else begin
         shadow_d = shadow_q;
      end

      case (state_q)
         LATCH: begin
            state_d = BLANK;
         end
         BLANK: begin
            if (cnt_s >= BLANK_LAST) begin
               state_d = ON;
            end else begin
               state_d = BLANK;
            end
         end
         ON: begin
            if (slot_wrap_s) begin
               state_d = (row_s == 3'd7) ? LATCH : BLANK;
            end else begin
               state_d = ON;
            end
            if (pwm_pass_s) begin
               row_sel_d  = row_onehot(row_s);
               col_data_d = shadow_row(shadow_q, row_s);
            end else begin
               row_sel_d  = 8'h00;
               col_data_d = 8'h00;
            end
         end
         default: begin
            state_d = LATCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LATCH;
         shadow_q     <= 64'h0;
         row_sel_q    <= 8'h00;
         col_data_q   <= 8'h00;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         row_sel_q    <= row_sel_d;
         col_data_q   <= col_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign row_sel    = row_sel_q;
   assign col_data   = col_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner: frame-level reference model plus directed checks.
module tb_dot_matrix_scanner;

   localparam int CLK_DIV   = 32;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 8 * CLK_DIV;

   logic        clk;
   logic        reset;
   logic [63:0] main_graphic;
   logic [31:0] brightness;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;

   int tests = 0;
   int fails = 0;
   int n     = 0;

   dot_matrix_scanner #(
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .main_graphic (main_graphic),
      .brightness   (brightness),
      .row_sel      (row_sel),
      .col_data     (col_data),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: k_m is the cycle index inside the current frame.
   int          k_m = 0;
   int          m_row;
   int          m_c;
   logic        m_lit;
   logic [63:0] m_img = 64'h0;
   logic        m_valid = 1'b0;
   logic [7:0]  exp_row = 8'h00;
   logic [7:0]  exp_col = 8'h00;
   logic        exp_fd  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         k_m     <= 0;
         m_valid <= 1'b1;
         exp_row <= 8'h00;
         exp_col <= 8'h00;
         exp_fd  <= 1'b0;
      end else begin
         m_row = k_m / CLK_DIV;
         m_c   = k_m % CLK_DIV;
         if (k_m == 0) m_img = main_graphic;
         m_lit = (m_c >= BLANK_CYC);
`ifdef SCANNER_PWM_EN
         if ((m_c % 16) > int'(brightness[3:0])) m_lit = 1'b0;
`endif
         exp_row <= m_lit ? 8'(1 << (7 - m_row)) : 8'h00;
         exp_col <= m_lit ? 8'(m_img >> (8 * (7 - m_row))) : 8'h00;
         exp_fd  <= (k_m == FRAME - 1);
         k_m     <= (k_m + 1) % FRAME;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         tests++;
         if (row_sel !== exp_row || col_data !== exp_col || frame_done !== exp_fd) begin
            fails++;
            $display("FAIL model_cmp t=%0t row_sel=%h/%h col_data=%h/%h frame_done=%b/%b (got/required)",
                     $time, row_sel, exp_row, col_data, exp_col, frame_done, exp_fd);
         end
         tests++;
         if ($countones(row_sel) > 1) begin
            fails++;
            $display("FAIL onehot t=%0t row_sel=%h required at most one bit", $time, row_sel);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      n++;
   endtask

   task automatic step_to(input int t);
      while (n < t) step();
   endtask

   int active;
   int exp_pwm3;
   int exp_b0;

   initial begin
`ifdef SCANNER_PWM_EN
      exp_pwm3 = 6;   // cnt 2,3,16,17,18,19
      exp_b0   = 1;   // cnt 16
`else
      exp_pwm3 = 30;
      exp_b0   = 30;
`endif
      reset        = 1'b1;
      main_graphic = 64'h8000_0000_0000_0001;
      brightness   = 32'd15;
      repeat (3) @(negedge clk);
      chk("reset_row_sel", {24'h0, row_sel}, 32'h0);
      chk("reset_col_data", {24'h0, col_data}, 32'h0);
      reset = 1'b0;
      n     = 0;

      // n counts negedges after release; the sample at n reflects cycle n-1.
      step_to(1);
      chk("latch_blank", {24'h0, row_sel}, 32'h0);
      step_to(3);
      chk("row0_row_sel", {24'h0, row_sel}, 32'h80);
      chk("row0_col_data", {24'h0, col_data}, 32'h80);

      step_to(100);
      main_graphic = 64'hFFFF_FFFF_FFFF_FFFF;
      step_to(110);
      chk("tear_row3_sel", {24'h0, row_sel}, 32'h10);
      chk("tear_row3_col", {24'h0, col_data}, 32'h00);
      step_to(227);
      chk("row7_row_sel", {24'h0, row_sel}, 32'h01);
      chk("row7_col_data", {24'h0, col_data}, 32'h01);
      step_to(255);
      chk("fd_before", {31'h0, frame_done}, 32'h0);
      step_to(256);
      chk("fd_first", {31'h0, frame_done}, 32'h1);
      step_to(257);
      chk("fd_one_cycle", {31'h0, frame_done}, 32'h0);
      step_to(355);
      chk("next_frame_row3_sel", {24'h0, row_sel}, 32'h10);
      chk("next_frame_row3_col", {24'h0, col_data}, 32'hFF);

      step_to(400);
      brightness = 32'd3;
      active = 0;
      for (int t = 417; t <= 448; t++) begin
         step_to(t);
         if (row_sel != 8'h00) active++;
      end
      chk("pwm3_active", active, exp_pwm3);
      step_to(512);
      chk("fd_second", {31'h0, frame_done}, 32'h1);

      step_to(682);
      reset = 1'b1;
      step_to(683);
      chk("midreset_row_sel", {24'h0, row_sel}, 32'h0);
      chk("midreset_col_data", {24'h0, col_data}, 32'h0);
      chk("midreset_fd", {31'h0, frame_done}, 32'h0);
      reset = 1'b0;
      n     = 0;
      step_to(3);
      chk("restart_row_sel", {24'h0, row_sel}, 32'h80);
      chk("restart_col_data", {24'h0, col_data}, 32'hFF);

      step_to(10);
      brightness = 32'd0;
      active = 0;
      for (int t = 33; t <= 64; t++) begin
         step_to(t);
         if (row_sel != 8'h00) active++;
      end
      chk("b0_active", active, exp_b0);

      while (frame_done !== 1'b1 && n < 400) step();
      chk("fd_after_restart", n, 256);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dot_matrix_scanner.md
DOT_MATRIX_SCANNER -- requirements
Module: dot_matrix_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1024, clk cycles per row slot; legal range 32..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 4, blanking cycles at the start of each row slot; CLK_DIV >= BLANK_CYC+16.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port main_graphic, input, 64, the memory-mapped 8x8 frame image from the memory control unit.
REQ-006 SHALL have port brightness, input, 32, the memory-mapped LED brightness word; only [3:0] is used.
REQ-007 SHALL have port row_sel, output, 8, one-hot active-high row drive.
REQ-008 SHALL have port col_data, output, 8, active-high column data; bit 7 is the leftmost column.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-010 SHALL keep a slot counter cnt (0..CLK_DIV-1) and a row counter row (0..7); cnt increments every clk; at CLK_DIV-1 it wraps to 0 and row increments, wrapping 7->0.
REQ-011 SHALL copy main_graphic into a 64-bit shadow register in every cycle where row==0 and cnt==0; changes to main_graphic at any other time SHALL NOT affect the frame in progress (no tearing).
REQ-012 SHALL map shadow bits so that row r shows shadow[63-8r -: 8]; row 0 = [63:56] and row 7 = [7:0].
REQ-013 SHALL use a 3-state FSM with states LATCH, BLANK and ON.
REQ-014 SHALL stay in LATCH for the single cycle row==0, cnt==0, then go to BLANK.
REQ-015 SHALL, in BLANK, drive row_sel=0 and col_data=0 while cnt < BLANK_CYC, then go to ON.
REQ-016 SHALL, in ON, drive row_sel=1<<(7-row) and col_data=shadow row, gated by PWM; it SHALL go to BLANK at a slot wrap with row!=7, or to LATCH at the wrap from row 7.
REQ-017 SHALL treat a LATCH cycle as blanked: row_sel=0, col_data=0.
REQ-018 SHALL apply PWM in ON: when cnt[3:0] <= brightness[3:0], output row_sel/col_data; otherwise force both to 0. Duty is (b+1)/16; b=15 gives continuous on.
REQ-019 SHALL register row_sel, col_data and frame_done, so each reflects the counter/FSM state of the previous cycle (latency 1 clk).
REQ-020 SHALL pulse frame_done high for exactly one cycle after the cycle with row==7 and cnt==CLK_DIV-1.
REQ-021 SHALL never drive more than one row_sel bit high in any cycle.
REQ-022 SHALL let a brightness change take effect on the next cycle, with no frame-boundary sync.

Reset
REQ-023 SHALL, on reset==1 at a clk edge, clear cnt, row, shadow, row_sel, col_data and frame_done to 0, and set the FSM to LATCH.
REQ-024 SHALL, in the first cycle after reset deasserts, latch main_graphic (row 0, cnt 0).
REQ-025 SHALL abort a frame when reset is applied mid-frame, with all outputs reaching 0 on the same edge and no frame_done pulse for that frame.

Configuration
REQ-026 SHALL compile the PWM dimming of REQ-018 only when SCANNER_PWM_EN is defined.
REQ-027 SHALL, without SCANNER_PWM_EN, ignore brightness and keep outputs continuously on for the whole ON state.

Structure
REQ-028 SHALL place ROWS=8, COLS=8 and the FSM state enum (LATCH, BLANK, ON) in the shared package scanner_pkg.
REQ-029 SHALL implement cnt/row generation, including the wrap strobes, in one sub-module, scan_prescaler.

Verification
REQ-030 SHALL be verified with CLK_DIV=32, BLANK_CYC=2 and SCANNER_PWM_EN defined, using these scenarios:
- Reset: main_graphic=64'h8000_0000_0000_0001, brightness=15 -> row_sel=8'h80, col_data=8'h80 from cycle 4; row 7 shows row_sel=8'h01, col_data=8'h01.
- Tearing: main_graphic changed to all-ones at row 3 -> current frame unchanged; next frame shows col_data=8'hFF in every row.
- PWM: brightness=3 -> in ON, outputs active only when cnt[3:0] is 0..3 (4 of 16 cycles).
- Frame timing: frame_done pulses once every 256 cycles; its first pulse comes 257 cycles after reset release.
- Mid-frame reset: reset at row 5, cnt 10 -> all outputs 0 next edge and the scan restarts at row 0.
- Without SCANNER_PWM_EN: brightness=0 -> ON is continuous for 30 of 32 cycles in each non-LATCH slot.
